i2s_rx_unit: RTL



---
 rtl/audioport_pkg.sv | 14 +
 rtl/i2s_rx_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/audioport_pkg.sv
// Shared audioport definitions; the I2S receiver constants and FSM state type
// live here alongside the transmitter's settings.
package audioport_pkg;

  localparam int I2S_RX_SLOT_BITS      = 32;
  localparam int I2S_RX_DATA_BITS      = 24;
  localparam int I2S_RX_TIMEOUT_CYCLES = 256;

  typedef enum logic {
    I2S_RX_UNLOCKED,
    I2S_RX_LOCKED
  } i2s_rx_state_t;

endpackage

// File: rtl/i2s_rx_unit.sv
// I2S receiver: oversamples sck/ws/sdo, locks to frame alignment and emits one stereo pair per frame.
// Optional lock-loss timeout on a stopped sck is enabled with `define I2S_RX_TIMEOUT_EN.
module i2s_rx_unit
  import audioport_pkg::*;
#(
  parameter int SLOT_BITS      = I2S_RX_SLOT_BITS,
  parameter int DATA_BITS      = I2S_RX_DATA_BITS
`ifdef I2S_RX_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = I2S_RX_TIMEOUT_CYCLES
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sck_in,
  input  logic                      ws_in,
  input  logic                      sdo_in,
  output logic [1:0][DATA_BITS-1:0] audio_out,
  output logic                      valid_out,
  output logic                      frame_err_out,
  output logic                      locked_out
);

  localparam int CNT_W = $clog2(SLOT_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W:0]   DATA_LIM  = (CNT_W + 1)'(DATA_BITS);

  logic sck_r, ws_r, sdo_r, sck_p, ws_p;
  logic rise, transition;

  logic [CNT_W-1:0]     bitcnt_reg;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] left_hold_reg;
  logic                 left_valid_reg;
  logic                 pair_pend_reg, err_pend_reg;

  i2s_rx_state_t state_reg, state_next;

  logic shift_en, last_data, left_take, pair_fire, slot_err, timeout_hit;

`ifdef I2S_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_reg <= '0;
    end else if (state_reg != I2S_RX_LOCKED || rise) begin
      to_cnt_reg <= '0;
    end else if (to_cnt_reg != TO_LIM) begin
      to_cnt_reg <= to_cnt_reg + 1'b1;
    end
  end

  assign timeout_hit = (state_reg == I2S_RX_LOCKED) && !rise && (to_cnt_reg == TO_LIM);
`else
  assign timeout_hit = 1'b0;
`endif

  assign rise       = sck_r & ~sck_p;
  assign transition = rise & (ws_r ^ ws_p);
  assign shift_next = {shift_reg[DATA_BITS-2:0], sdo_r};

  always_comb begin
    state_next = state_reg;
    slot_err   = 1'b0;
    shift_en   = rise && !transition && ({1'b0, bitcnt_reg} < DATA_LIM);
    last_data  = rise && !transition && (bitcnt_reg == DATA_LAST);
    left_take  = last_data && !ws_r;
    pair_fire  = last_data && ws_r && (state_reg == I2S_RX_LOCKED) && left_valid_reg;
    case (state_reg)
      I2S_RX_UNLOCKED: begin
        // Only a left-slot start (ws 1->0) gives a trustworthy slot boundary.
        if (transition && ws_p && !ws_r) begin
          state_next = I2S_RX_LOCKED;
        end
      end
      I2S_RX_LOCKED: begin
        if (transition) begin
          slot_err = (bitcnt_reg != LAST_BIT);
        end else if (rise) begin
          slot_err = (bitcnt_reg == LAST_BIT);
        end
        if (slot_err || timeout_hit) begin
          state_next = I2S_RX_UNLOCKED;
        end
      end
      default: state_next = I2S_RX_UNLOCKED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= I2S_RX_UNLOCKED;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_r          <= 1'b0;
      ws_r           <= 1'b0;
      sdo_r          <= 1'b0;
      sck_p          <= 1'b0;
      ws_p           <= 1'b0;
      bitcnt_reg     <= '0;
      shift_reg      <= '0;
      left_hold_reg  <= '0;
      left_valid_reg <= 1'b0;
      pair_pend_reg  <= 1'b0;
      err_pend_reg   <= 1'b0;
      audio_out      <= '0;
      valid_out      <= 1'b0;
      frame_err_out  <= 1'b0;
    end else begin
      sck_r <= sck_in;
      ws_r  <= ws_in;
      sdo_r <= sdo_in;
      sck_p <= sck_r;
      if (rise) begin
        ws_p <= ws_r;
      end

      if (transition) begin
        bitcnt_reg <= '0;
      end else if (rise) begin
        bitcnt_reg <= bitcnt_reg + 1'b1;
      end

      if (shift_en) begin
        shift_reg <= shift_next;
      end

      // A held left word is only good if it was gathered entirely while locked.
      if (left_take) begin
        left_hold_reg <= shift_next;
      end
      if (slot_err || timeout_hit || pair_fire) begin
        left_valid_reg <= 1'b0;
      end else if (left_take) begin
        left_valid_reg <= (state_reg == I2S_RX_LOCKED);
      end

      // Right word is complete in shift_reg one cycle after its bit-0 rise.
      pair_pend_reg <= pair_fire;
      err_pend_reg  <= slot_err;
      valid_out     <= pair_pend_reg;
      frame_err_out <= err_pend_reg;
      if (pair_pend_reg) begin
        audio_out[0] <= left_hold_reg;
        audio_out[1] <= shift_reg;
      end
    end
  end

  assign locked_out = (state_reg == I2S_RX_LOCKED);

endmodule
